// File: rtl/div_rate_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_rate_ctrl_pkg                                            |
// | Description : Shared state encodings and mode constants for div_rate_ctrl. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package div_rate_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  localparam logic MODE_FREE  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  function automatic logic state_is_busy(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_BURST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_rate_ctrl_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_rate_ctrl_core                                           |
// | Description : Divide counter, clk_out toggle and active terminal count.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module div_rate_ctrl_core #(
  parameter int CNT_W         = 31,
  parameter int DEFAULT_COUNT = 200
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  output logic             at_term,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] c_default_count = CNT_W'(DEFAULT_COUNT);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_active;
  logic             r_clk_out;

  assign at_term = run && (r_count == r_active);
  assign clk_out = r_clk_out;

  // Active only changes when count is being zeroed, so count never exceeds it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_active  <= c_default_count;
      r_clk_out <= 1'b0;
    end else begin
      if (clr) begin
        r_count   <= '0;
        r_clk_out <= 1'b0;
      end else if (at_term) begin
        r_count   <= '0;
        r_clk_out <= ~r_clk_out;
      end else if (run) begin
        r_count   <= r_count + CNT_W'(1);
      end
      if (load_en) begin
        r_active <= load_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_rate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_rate_ctrl                                                |
// | Description : Glitch-free run-time clock divider controller with free-run  |
// |               and burst modes. Define DIV_TICK_CNT_EN for tick_cnt output. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module div_rate_ctrl
  import div_rate_ctrl_pkg::*;
#(
  parameter int CNT_W         = 31,
  parameter int DEFAULT_COUNT = 200,
  parameter int BURST_W       = 8
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_count,
  output logic               cfg_ready,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [BURST_W-1:0] burst_len,
  output logic               busy,
  output logic               tick,
  output logic               done,
`ifdef DIV_TICK_CNT_EN
  output logic [15:0]        tick_cnt,
`endif
  output logic               clk_out
);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               w_busy;
  logic               w_done_nxt;
  logic               r_tick;
  logic               r_done;
  logic               r_pending;
  logic [CNT_W-1:0]   r_pend_count;
  logic [BURST_W-1:0] r_remaining;

  logic               w_idle;
  logic               w_accept;
  logic               w_stop_act;
  logic               w_run;
  logic               w_at_term;
  logic               w_fall;
  logic               w_burst_end;
  logic               w_go;
  logic               w_apply;
  logic               w_load_en;
  logic [CNT_W-1:0]   w_load_val;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = cfg_valid && !r_pending;
  assign w_stop_act  = stop && w_busy;
  assign w_run       = w_busy && !stop;
  assign w_fall      = w_at_term && clk_out;
  assign w_burst_end = (r_state == ST_BURST) && w_fall && (r_remaining == BURST_W'(1));
  assign w_go        = w_idle && start && !stop && ((mode == MODE_FREE) || (burst_len != '0));

  // A pending count lands on a half-period boundary, on stop, or once idle.
  assign w_apply     = r_pending && (w_at_term || w_stop_act || w_idle);
  assign w_load_en   = w_apply || (w_accept && w_idle);
  assign w_load_val  = w_apply ? r_pend_count : cfg_count;

  div_rate_ctrl_core #(
    .CNT_W         (CNT_W),
    .DEFAULT_COUNT (DEFAULT_COUNT)
  ) u_core (
    .clk_in   (clk_in),
    .rst      (rst),
    .run      (w_run),
    .clr      (w_stop_act),
    .load_en  (w_load_en),
    .load_val (w_load_val),
    .at_term  (w_at_term),
    .clk_out  (clk_out)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (mode == MODE_FREE) begin
            w_state_nxt = ST_RUN;
          end else if (burst_len != '0) begin
            w_state_nxt = ST_BURST;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (stop || w_burst_end) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = state_is_busy(r_state);
    w_done_nxt = w_burst_end;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_tick       <= 1'b0;
      r_done       <= 1'b0;
      r_pending    <= 1'b0;
      r_pend_count <= '0;
      r_remaining  <= '0;
    end else begin
      r_tick <= w_at_term;
      r_done <= w_done_nxt;
      if (w_accept && !w_idle) begin
        r_pending    <= 1'b1;
        r_pend_count <= cfg_count;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
      if (w_go && (mode == MODE_BURST)) begin
        r_remaining <= burst_len;
      end else if ((r_state == ST_BURST) && w_fall) begin
        r_remaining <= r_remaining - BURST_W'(1);
      end
    end
  end

`ifdef DIV_TICK_CNT_EN
  logic [15:0] r_tick_cnt;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_go) begin
      r_tick_cnt <= '0;
    end else if (w_at_term) begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  assign tick_cnt = r_tick_cnt;
`endif

  assign cfg_ready = !r_pending;
  assign busy      = w_busy;
  assign tick      = r_tick;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_div_rate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_div_rate_ctrl                                             |
// | Description : Directed self-checking bench for div_rate_ctrl.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_div_rate_ctrl;

  localparam int CNT_W   = 31;
  localparam int BURST_W = 8;

  logic               clk_in = 1'b0;
  logic               rst;
  logic               cfg_valid;
  logic [CNT_W-1:0]   cfg_count;
  logic               cfg_ready;
  logic               start;
  logic               stop;
  logic               mode;
  logic [BURST_W-1:0] burst_len;
  logic               busy;
  logic               tick;
  logic               done;
  logic               clk_out;

  int n_cmp = 0;
  int n_err = 0;

  div_rate_ctrl #(
    .CNT_W         (CNT_W),
    .DEFAULT_COUNT (200),
    .BURST_W       (BURST_W)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_count (cfg_count),
    .cfg_ready (cfg_ready),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .burst_len (burst_len),
    .busy      (busy),
    .tick      (tick),
    .done      (done),
`ifdef DIV_TICK_CNT_EN
    .tick_cnt  (),
`endif
    .clk_out   (clk_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < limit);
  endtask

  task automatic pulse_start(input logic m, input logic [BURST_W-1:0] len);
    start = 1'b1; mode = m; burst_len = len;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic cfg_idle(input logic [CNT_W-1:0] c);
    cfg_valid = 1'b1; cfg_count = c;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    int ticks;
    int done_at;
    int done_cnt;

    rst = 1'b1; cfg_valid = 1'b0; cfg_count = '0; start = 1'b0;
    stop = 1'b0; mode = 1'b0; burst_len = '0;
    #2;
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_busy",    32'(busy), 0);
    check("rst_tick",    32'(tick), 0);
    check("rst_done",    32'(done), 0);
    check("rst_ready",   32'(cfg_ready), 1);
    step(); step();
    rst = 1'b0;
    step();

    // Default count 200: half period 201 cycles.
    pulse_start(1'b0, 8'd0);
    check("run_busy", 32'(busy), 1);
    wait_tick(300, n);
    check("run_first_tick", 32'(n), 201);
    check("run_clk_hi", 32'(clk_out), 1);
    wait_tick(300, n);
    check("run_second_half", 32'(n), 201);
    check("run_clk_lo", 32'(clk_out), 0);
    wait_tick(300, n);
    step(); step(); step();
    check("pre_stop_clk", 32'(clk_out), 1);
    do_stop();
    check("stop_clk_out", 32'(clk_out), 0);
    check("stop_busy",    32'(busy), 0);
    check("stop_done",    32'(done), 0);
    check("stop_tick",    32'(tick), 0);

    // start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1; mode = 1'b0;
    step();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 0);
    step(); step();
    check("startstop_busy2", 32'(busy), 0);
    check("startstop_clk",   32'(clk_out), 0);

    // Terminal count 0: toggle every cycle.
    cfg_idle('0);
    check("cfg0_ready", 32'(cfg_ready), 1);
    pulse_start(1'b0, 8'd0);
    step();
    check("c0_tick1", 32'(tick), 1);
    check("c0_clk1",  32'(clk_out), 1);
    step();
    check("c0_tick2", 32'(tick), 1);
    check("c0_clk2",  32'(clk_out), 0);
    step();
    check("c0_clk3",  32'(clk_out), 1);
    do_stop();
    check("c0_stop_clk", 32'(clk_out), 0);

    // burst_len=0 start is ignored.
    pulse_start(1'b1, 8'd0);
    check("burst0_busy", 32'(busy), 0);

    // Burst: count 3 (4-cycle halves), 2 periods -> 4 ticks, done on the last.
    cfg_idle(31'd3);
    pulse_start(1'b1, 8'd2);
    check("burst_busy", 32'(busy), 1);
    ticks = 0; done_at = 0; done_cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (tick) ticks++;
      if (done) begin
        done_cnt++;
        done_at = i;
        check("burst_done_tick", 32'(tick), 1);
        check("burst_done_clk",  32'(clk_out), 0);
        check("burst_done_busy", 32'(busy), 0);
      end
    end
    check("burst_ticks",    32'(ticks), 4);
    check("burst_done_at",  32'(done_at), 16);
    check("burst_done_cnt", 32'(done_cnt), 1);
    check("burst_end_clk",  32'(clk_out), 0);

    // Runtime update: 9 -> 4 applied at the next boundary.
    cfg_idle(31'd9);
    pulse_start(1'b0, 8'd0);
    wait_tick(30, n);
    check("upd_first_half", 32'(n), 10);
    step(); step(); step();
    cfg_valid = 1'b1; cfg_count = 31'd4;
    step();
    cfg_valid = 1'b0;
    check("upd_ready_low", 32'(cfg_ready), 0);
    wait_tick(30, n);
    check("upd_cur_half", 32'(n + 4), 10);
    check("upd_ready_hi", 32'(cfg_ready), 1);
    wait_tick(30, n);
    check("upd_new_half1", 32'(n), 5);
    wait_tick(30, n);
    check("upd_new_half2", 32'(n), 5);
    do_stop();

    // Asynchronous reset in the middle of a burst.
    cfg_idle(31'd5);
    pulse_start(1'b1, 8'd3);
    for (int i = 0; i < 8; i++) step();
    check("mid_clk_hi", 32'(clk_out), 1);
    rst = 1'b1;
    #1;
    check("arst_clk_out", 32'(clk_out), 0);
    check("arst_busy",    32'(busy), 0);
    check("arst_tick",    32'(tick), 0);
    check("arst_done",    32'(done), 0);
    check("arst_ready",   32'(cfg_ready), 1);
    step();
    rst = 1'b0;
    step();
    pulse_start(1'b0, 8'd0);
    wait_tick(300, n);
    check("arst_default_half", 32'(n), 201);
    do_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
